frame_out_scheduler: RTL
========================

Name: frame_out_scheduler

Overview:
- Output-side sequencer in the clk_out domain, between the frame FIFO and the shared 16-bit-word serializer that drives data_out_ch1..8 / data_vld_ch1..8.
- Accepts one descriptor per detected frame: channel, length and CRC result.
- CRC-good frames with a valid channel: reads the payload words from the FIFO and hands them one at a time to the serializer, tagged with the channel.
- CRC-bad frames or frames with an invalid channel: drains the payload words from the FIFO without sending them.

Parameters:
- MAX_WORDS, 8, maximum payload words per frame (128 bits).
- TIMEOUT_CYC, 64, number of consecutive cycles with fifo_empty that triggers an abort while in READ or DRAIN.
- W, 16, FIFO and serializer word width.

Ports:
- clk_out  in  1  scheduler clock.
- rst_n  in  1  asynchronous reset, active-low.
- desc_vld  in  1  descriptor valid.
- desc_rdy  out  1  descriptor accept; high only in IDLE.
- desc_ch  in  8  one-hot channel select.
- desc_len  in  3  payload words minus 1 (0..7 means 1..8 words).
- desc_crc_ok  in  1  1 means the frame's CRC matched.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  FIFO read strobe; data is returned 1 cycle later.
- fifo_rd_data  in  W  FIFO read data.
- ser_rdy  in  1  serializer can accept a word; serializer drops it the cycle after ser_load.
- ser_load  out  1  one-cycle word hand-off pulse.
- ser_word  out  W  word to serialize.
- ser_ch  out  8  one-hot target channel.
- ser_last  out  1  marks the last word of the frame; qualified by ser_load.
- crc_valid_o  out  1  one-cycle pulse at the start of a good frame (first ser_load).
- crc_err  out  1  one-cycle pulse when a frame is dropped (CRC bad or channel not one-hot).
- frame_abort  out  1  one-cycle pulse on timeout.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset: all outputs 0 except desc_rdy=1; state=IDLE; word counter=0; timeout counter=0. Reset asserted mid-frame abandons the frame immediately; the FIFO is not drained.
- State machine: IDLE, READ, LOAD, GAP, DRAIN.
- IDLE:
  - On desc_vld&&desc_rdy, latch ch/len/crc_ok and set word count=0.
  - Go to READ if crc_ok and desc_ch is one-hot (exactly one bit set); otherwise go to DRAIN.
- READ:
  - When !fifo_empty && ser_rdy: assert fifo_rd_en (1 cycle), go to LOAD.
  - Otherwise stay; count fifo_empty cycles only (ser_rdy low does not count toward timeout).
- LOAD:
  - Assert ser_load=1, ser_word=fifo_rd_data, ser_ch=latched ch, ser_last=(count==len).
  - crc_valid_o=1 when count==0.
  - count++. If last, go to IDLE; else go to GAP.
- GAP: one idle cycle that lets ser_rdy fall; then go to READ.
- Resulting throughput: at most one word per 3 cycles.
- DRAIN:
  - Each cycle with !fifo_empty, assert fifo_rd_en and count++. Read data is discarded.
  - When count reaches len+1, pulse crc_err and go to IDLE in the same cycle as the final rd_en.
- Timeout:
  - In READ or DRAIN, the timeout counter increments on each cycle with fifo_empty and clears on every rd_en.
  - At TIMEOUT_CYC-1: pulse frame_abort, go to IDLE. No ser_last is issued for the partial frame.
- Latency: descriptor accepted at cycle 0 → fifo_rd_en at cycle 1 (best case) → ser_load at cycle 2.
- desc_rdy=0 outside IDLE; a descriptor is never accepted in the same cycle the previous frame finishes.
- ser_* outputs hold their value between loads; only ser_load qualifies them.
- fifo_rd_en is never asserted while fifo_empty=1.

Optional Feature:
- Macro: FRAME_SCHED_STATS_EN.
- When defined:
  - Adds outputs stat_sent[15:0], stat_dropped[15:0] and stat_abort[15:0].
  - Counters increment on the final ser_load, on crc_err, and on frame_abort respectively.
  - Counters saturate at 16'hFFFF and reset to 0.
- When undefined: these ports and counters are absent; core behaviour is unchanged.

Decomposition:
- Package frame_sched_pkg holds:
  - state enum sched_state_t {IDLE, READ, LOAD, GAP, DRAIN};
  - MAX_WORDS, W;
  - function is_onehot8();
  - HEADER=32'hE0E0E0E0 and TRAILER=32'h0E0E0E0E (shared with the detector).
- Sub-module frame_sched_stats contains the saturating counters and is instantiated only under FRAME_SCHED_STATS_EN.

Test Plan:
- Good 1-word frame: desc_ch=8'h01, len=0, crc_ok=1, FIFO holds 16'hA55A. Expect:
  - fifo_rd_en at cycle 1;
  - ser_load at cycle 2 with ser_word=A55A, ser_ch=01, ser_last=1;
  - crc_valid_o pulse at cycle 2.
- Good 8-word frame: ch=8'h02, len=7, words 0123,4567,…,3210. Expect 8 ser_loads, each 3 cycles apart, in FIFO order; ser_last only on the 8th; one crc_valid_o.
- CRC bad: ch=8'h01, len=0, crc_ok=0, FIFO holds 1234. Expect one fifo_rd_en, crc_err pulse, zero ser_load; FIFO empty afterwards.
- Invalid channel: ch=8'h0C, len=3, crc_ok=1. Expect 4 drain reads, then crc_err; no ser_load.
- Backpressure/starvation:
  - ser_rdy held low 20 cycles: no rd_en, no abort.
  - FIFO held empty with len=3 after 1 word: frame_abort at 64 empty cycles, then back to IDLE.
- Reset during a 4-word frame after 2 loads: all outputs go to their reset values immediately; a new descriptor is accepted cleanly after reset is released.

Source files
------------

// File: rtl/frame_sched_pkg.sv
// Shared types and constants for the frame output scheduler.
// HEADER/TRAILER are the frame markers the upstream detector also uses.
package frame_sched_pkg;

  localparam int W         = 16;
  localparam int MAX_WORDS = 8;

  localparam logic [31:0] HEADER  = 32'hE0E0E0E0;
  localparam logic [31:0] TRAILER = 32'h0E0E0E0E;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    LOAD  = 3'd2,
    GAP   = 3'd3,
    DRAIN = 3'd4
  } sched_state_t;

  // True when exactly one bit of the channel select is set.
  function automatic logic is_onehot8(input logic [7:0] v);
    return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
  endfunction

endpackage

// File: rtl/frame_out_scheduler_if.sv
// Descriptor, FIFO-read and serializer signals of the frame output scheduler.
// Descriptor handshake: a descriptor transfers on a rising clk_out edge where desc_vld && desc_rdy;
// desc_vld must hold its payload stable until that edge, and desc_rdy never depends on desc_vld.
interface frame_out_scheduler_if;

  logic                        desc_vld;
  logic                        desc_rdy;
  logic [7:0]                  desc_ch;
  logic [2:0]                  desc_len;
  logic                        desc_crc_ok;

  logic                        fifo_empty;
  logic                        fifo_rd_en;
  logic [frame_sched_pkg::W-1:0] fifo_rd_data;

  logic                        ser_rdy;
  logic                        ser_load;
  logic [frame_sched_pkg::W-1:0] ser_word;
  logic [7:0]                  ser_ch;
  logic                        ser_last;

  logic                        crc_valid_o;
  logic                        crc_err;
  logic                        frame_abort;
  logic                        busy;

  modport master (
    input  desc_vld, desc_ch, desc_len, desc_crc_ok,
    input  fifo_empty, fifo_rd_data, ser_rdy,
    output desc_rdy, fifo_rd_en, ser_load, ser_word, ser_ch, ser_last,
    output crc_valid_o, crc_err, frame_abort, busy
  );

  modport slave (
    output desc_vld, desc_ch, desc_len, desc_crc_ok,
    output fifo_empty, fifo_rd_data, ser_rdy,
    input  desc_rdy, fifo_rd_en, ser_load, ser_word, ser_ch, ser_last,
    input  crc_valid_o, crc_err, frame_abort, busy
  );

endinterface

// File: rtl/frame_sched_stats.sv
// Saturating frame counters (sent, dropped, aborted); only built with FRAME_SCHED_STATS_EN.
module frame_sched_stats (
  input  logic        clk_out,
  input  logic        rst_n,
  input  logic        inc_sent,
  input  logic        inc_dropped,
  input  logic        inc_abort,
  output logic [15:0] stat_sent,
  output logic [15:0] stat_dropped,
  output logic [15:0] stat_abort
);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      stat_sent    <= '0;
      stat_dropped <= '0;
      stat_abort   <= '0;
    end else begin
      if (inc_sent)    stat_sent    <= sat_inc(stat_sent);
      if (inc_dropped) stat_dropped <= sat_inc(stat_dropped);
      if (inc_abort)   stat_abort   <= sat_inc(stat_abort);
    end
  end

endmodule

// File: rtl/frame_out_scheduler.sv
// Sequences descriptor-driven FIFO reads into the shared word serializer, dropping bad frames.
// Optional counters via FRAME_SCHED_STATS_EN.
module frame_out_scheduler
  import frame_sched_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                  clk_out,
  input  logic                  rst_n,
  frame_out_scheduler_if.master bus,
  output sched_state_t          state_dbg
`ifdef FRAME_SCHED_STATS_EN
  ,
  output logic [15:0]           stat_sent,
  output logic [15:0]           stat_dropped,
  output logic [15:0]           stat_abort
`endif
);

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  sched_state_t  state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    ch_q, ch_d;
  logic [2:0]    len_q, len_d;

  logic [W-1:0]  word_q;
  logic [7:0]    ser_ch_q;
  logic          last_q;

  logic rd_en, load, crc_valid, crc_err, abort, is_last;

  assign is_last = (cnt_q == {1'b0, len_q});

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    ch_d      = ch_q;
    len_d     = len_q;
    rd_en     = 1'b0;
    load      = 1'b0;
    crc_valid = 1'b0;
    crc_err   = 1'b0;
    abort     = 1'b0;

    unique case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (bus.desc_vld) begin
          ch_d    = bus.desc_ch;
          len_d   = bus.desc_len;
          cnt_d   = '0;
          state_d = (bus.desc_crc_ok && is_onehot8(bus.desc_ch)) ? READ : DRAIN;
        end
      end
      READ: begin
        if (!bus.fifo_empty && bus.ser_rdy) begin
          rd_en   = 1'b1;
          tmo_d   = '0;
          state_d = LOAD;
        end else if (bus.fifo_empty) begin
          // A stalled serializer is not starvation; only empty cycles age the frame.
          if (tmo_q == TMO_LAST) begin
            abort   = 1'b1;
            state_d = IDLE;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
      end
      LOAD: begin
        load      = 1'b1;
        crc_valid = (cnt_q == 4'd0);
        cnt_d     = cnt_q + 4'd1;
        state_d   = is_last ? IDLE : GAP;
      end
      GAP: begin
        state_d = READ;
      end
      DRAIN: begin
        if (!bus.fifo_empty) begin
          rd_en = 1'b1;
          tmo_d = '0;
          cnt_d = cnt_q + 4'd1;
          if (is_last) begin
            crc_err = 1'b1;
            state_d = IDLE;
          end
        end else if (tmo_q == TMO_LAST) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tmo_q   <= '0;
      ch_q    <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      ch_q    <= ch_d;
      len_q   <= len_d;
    end
  end

  // Serializer outputs track the live word during LOAD and hold it afterwards.
  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      word_q   <= '0;
      ser_ch_q <= '0;
      last_q   <= 1'b0;
    end else if (load) begin
      word_q   <= bus.fifo_rd_data;
      ser_ch_q <= ch_q;
      last_q   <= is_last;
    end
  end

  assign bus.desc_rdy    = (state_q == IDLE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.fifo_rd_en  = rd_en;
  assign bus.ser_load    = load;
  assign bus.ser_word    = load ? bus.fifo_rd_data : word_q;
  assign bus.ser_ch      = load ? ch_q : ser_ch_q;
  assign bus.ser_last    = load ? is_last : last_q;
  assign bus.crc_valid_o = crc_valid;
  assign bus.crc_err     = crc_err;
  assign bus.frame_abort = abort;
  assign state_dbg       = state_q;

`ifdef FRAME_SCHED_STATS_EN
  frame_sched_stats u_stats (
    .clk_out      (clk_out),
    .rst_n        (rst_n),
    .inc_sent     (load && is_last),
    .inc_dropped  (crc_err),
    .inc_abort    (abort),
    .stat_sent    (stat_sent),
    .stat_dropped (stat_dropped),
    .stat_abort   (stat_abort)
  );
`endif

endmodule
